// File: rtl/osl_link_arb.sv
// Channel arbiter/router sharing one osl_rxtx host port between NCH clients; TX words carry {id, payload}.
// Define OSL_ARB_FIXED_PRIO_EN for fixed lowest-index priority; default build is round-robin.
module osl_link_arb #(
    parameter int  WORDSZ = 16,
    parameter int  CHIDSZ = 2,
    parameter int  NCH    = 4,
    localparam int PAYSZ  = WORDSZ - CHIDSZ
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic [NCH-1:0]         cl_tx_req,
    input  logic [NCH*PAYSZ-1:0]   cl_tx_data,
    output logic [NCH-1:0]         cl_tx_ack,
    output logic [NCH-1:0]         cl_rx_valid,
    output logic [NCH*PAYSZ-1:0]   cl_rx_data,
    input  logic [NCH-1:0]         cl_rx_ack,
    output logic                   link_cs,
    output logic                   link_wr,
    output logic [WORDSZ-1:0]      link_din,
    input  logic                   link_dir,
    output logic                   link_rd,
    input  logic [WORDSZ-1:0]      link_dout,
    input  logic                   link_dor
);

    typedef enum logic [1:0] {T_IDLE, T_WRITE, T_HOLD, T_WAIT} txState_t;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_HOLD} rxState_t;

    txState_t          r_txState;
    rxState_t          r_rxState;
    logic              r_linkWr;
    logic              r_linkRd;
    logic [NCH-1:0]    r_txAck;
    logic [WORDSZ-1:0] r_linkDin;
    logic [NCH-1:0]    r_rxValid;
    logic [PAYSZ-1:0]  r_rxData [NCH];

    logic              w_grantValid;
    logic [CHIDSZ-1:0] w_grantId;
    logic [PAYSZ-1:0]  w_grantData;

`ifdef OSL_ARB_FIXED_PRIO_EN
    // Scan downward so the lowest requesting index is the last, winning assignment.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantId    = '0;
        w_grantData  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (cl_tx_req[i]) begin
                w_grantValid = 1'b1;
                w_grantId    = CHIDSZ'(i);
                w_grantData  = cl_tx_data[i*PAYSZ +: PAYSZ];
            end
        end
    end
`else
    logic [CHIDSZ-1:0] r_rrPtr;
    logic [CHIDSZ-1:0] w_scanIdx;

    // NCH == 2**CHIDSZ, so the CHIDSZ-bit add wraps modulo NCH for free.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantId    = '0;
        w_grantData  = '0;
        w_scanIdx    = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            w_scanIdx = r_rrPtr + CHIDSZ'(k);
            if (cl_tx_req[w_scanIdx]) begin
                w_grantValid = 1'b1;
                w_grantId    = w_scanIdx;
                w_grantData  = cl_tx_data[w_scanIdx*PAYSZ +: PAYSZ];
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_txState <= T_IDLE;
            r_linkWr  <= 1'b0;
            r_txAck   <= '0;
            r_linkDin <= '0;
`ifndef OSL_ARB_FIXED_PRIO_EN
            r_rrPtr   <= '0;
`endif
        end else begin
            r_linkWr <= 1'b0;
            r_txAck  <= '0;
            case (r_txState)
                T_IDLE: begin
                    if (link_dir && w_grantValid) begin
                        r_linkDin <= {w_grantId, w_grantData};
                        r_linkWr  <= 1'b1;
                        r_txAck   <= NCH'(1) << w_grantId;
`ifndef OSL_ARB_FIXED_PRIO_EN
                        r_rrPtr   <= w_grantId + CHIDSZ'(1);
`endif
                        r_txState <= T_WRITE;
                    end
                end
                T_WRITE: r_txState <= T_HOLD;
                // Covers the cycle osl_rxtx needs before host_dir reflects the write.
                T_HOLD:  r_txState <= T_WAIT;
                T_WAIT:  if (link_dir) r_txState <= T_IDLE;
                default: r_txState <= T_IDLE;
            endcase
        end
    end

    logic [CHIDSZ-1:0] w_rxId;
    logic              w_rxLoad;
    logic [NCH-1:0]    w_rxLoadVec;

    assign w_rxId      = link_dout[WORDSZ-1 -: CHIDSZ];
    assign w_rxLoad    = (r_rxState == R_IDLE) && link_dor && !r_rxValid[w_rxId];
    assign w_rxLoadVec = w_rxLoad ? (NCH'(1) << w_rxId) : '0;

    // A full target register stalls the whole link; the word stays in osl_rxtx until freed.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_rxState <= R_IDLE;
            r_linkRd  <= 1'b0;
            r_rxValid <= '0;
            for (int i = 0; i < NCH; i++) r_rxData[i] <= '0;
        end else begin
            r_linkRd  <= 1'b0;
            r_rxValid <= (r_rxValid & ~cl_rx_ack) | w_rxLoadVec;
            case (r_rxState)
                R_IDLE: begin
                    if (w_rxLoad) begin
                        r_rxData[w_rxId] <= link_dout[PAYSZ-1:0];
                        r_linkRd         <= 1'b1;
                        r_rxState        <= R_READ;
                    end
                end
                R_READ:  r_rxState <= R_HOLD;
                R_HOLD:  r_rxState <= R_IDLE;
                default: r_rxState <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        cl_rx_data = '0;
        for (int i = 0; i < NCH; i++) cl_rx_data[i*PAYSZ +: PAYSZ] = r_rxData[i];
    end

    assign cl_tx_ack   = r_txAck;
    assign cl_rx_valid = r_rxValid;
    assign link_wr     = r_linkWr;
    assign link_rd     = r_linkRd;
    assign link_din    = r_linkDin;
    assign link_cs     = r_linkWr | r_linkRd;

endmodule

// File: tb/tb_osl_link_arb.sv
// Self-checking bench for osl_link_arb: directed scenarios, then randomized traffic checked
// every cycle against a transaction-level reference model.
module tb_osl_link_arb;

    localparam int WORDSZ = 16;
    localparam int CHIDSZ = 2;
    localparam int NCH    = 4;
    localparam int PAYSZ  = WORDSZ - CHIDSZ;

    logic                 clk = 1'b0;
    logic                 resetb = 1'b0;
    logic [NCH-1:0]       cl_tx_req = '0;
    logic [NCH*PAYSZ-1:0] cl_tx_data = '0;
    logic [NCH-1:0]       cl_tx_ack;
    logic [NCH-1:0]       cl_rx_valid;
    logic [NCH*PAYSZ-1:0] cl_rx_data;
    logic [NCH-1:0]       cl_rx_ack = '0;
    logic                 link_cs;
    logic                 link_wr;
    logic [WORDSZ-1:0]    link_din;
    logic                 link_dir = 1'b0;
    logic                 link_rd;
    logic [WORDSZ-1:0]    link_dout = '0;
    logic                 link_dor = 1'b0;

    osl_link_arb #(.WORDSZ(WORDSZ), .CHIDSZ(CHIDSZ), .NCH(NCH)) dut (
        .clk(clk), .resetb(resetb),
        .cl_tx_req(cl_tx_req), .cl_tx_data(cl_tx_data), .cl_tx_ack(cl_tx_ack),
        .cl_rx_valid(cl_rx_valid), .cl_rx_data(cl_rx_data), .cl_rx_ack(cl_rx_ack),
        .link_cs(link_cs), .link_wr(link_wr), .link_din(link_din), .link_dir(link_dir),
        .link_rd(link_rd), .link_dout(link_dout), .link_dor(link_dor)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: stage counters for each direction plus expected client-visible state.
    int                mTxStage;
    int                mRxStage;
    int                mRr;
    logic              mWr;
    logic              mRd;
    logic [NCH-1:0]    mAck;
    logic [NCH-1:0]    mValid;
    logic [WORDSZ-1:0] mDin;
    logic [PAYSZ-1:0]  mData [NCH];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic void modelReset();
        mTxStage = 0;
        mRxStage = 0;
        mRr      = 0;
        mWr      = 1'b0;
        mRd      = 1'b0;
        mAck     = '0;
        mValid   = '0;
        mDin     = '0;
        for (int i = 0; i < NCH; i++) mData[i] = '0;
    endfunction

    // Predicts the outputs after the coming clock edge from the inputs currently driven.
    function automatic void modelStep();
        int w;
        int c;
        int idx;
        logic [NCH-1:0] loadVec;
        if (!resetb) begin
            modelReset();
            return;
        end
        mWr = 1'b0;
        mAck = '0;
        case (mTxStage)
            0: if (link_dir && cl_tx_req != '0) begin
                w = -1;
                for (int k = 0; k < NCH; k++) begin
`ifdef OSL_ARB_FIXED_PRIO_EN
                    idx = k;
`else
                    idx = (mRr + k) % NCH;
`endif
                    if (w < 0 && cl_tx_req[idx]) w = idx;
                end
                mDin = WORDSZ'(w * (1 << PAYSZ) + int'(cl_tx_data[w*PAYSZ +: PAYSZ]));
                mWr = 1'b1;
                mAck[w] = 1'b1;
                mRr = (w + 1) % NCH;
                mTxStage = 1;
            end
            1: mTxStage = 2;
            2: mTxStage = 3;
            default: if (link_dir) mTxStage = 0;
        endcase
        mRd = 1'b0;
        loadVec = '0;
        case (mRxStage)
            0: if (link_dor) begin
                c = int'(link_dout) / (1 << PAYSZ);
                if (!mValid[c]) begin
                    mData[c] = PAYSZ'(int'(link_dout) % (1 << PAYSZ));
                    loadVec[c] = 1'b1;
                    mRd = 1'b1;
                    mRxStage = 1;
                end
            end
            1: mRxStage = 2;
            default: mRxStage = 0;
        endcase
        mValid = (mValid & ~cl_rx_ack) | loadVec;
    endfunction

    task automatic compareAll();
        logic [NCH*PAYSZ-1:0] expData;
        for (int i = 0; i < NCH; i++) expData[i*PAYSZ +: PAYSZ] = mData[i];
        checkOutput("tx_ack", 64'(cl_tx_ack), 64'(mAck));
        checkOutput("link_wr", 64'(link_wr), 64'(mWr));
        checkOutput("link_din", 64'(link_din), 64'(mDin));
        checkOutput("link_rd", 64'(link_rd), 64'(mRd));
        checkOutput("link_cs", 64'(link_cs), 64'(mWr | mRd));
        checkOutput("rx_valid", 64'(cl_rx_valid), 64'(mValid));
        checkOutput("rx_data", 64'(cl_rx_data), 64'(expData));
    endtask

    // One clock: predict, clock, check just after the edge, return on the falling edge.
    task automatic applyStimulus();
        modelStep();
        @(posedge clk);
        #1;
        compareAll();
        @(negedge clk);
    endtask

    task automatic randomInputs();
        for (int i = 0; i < NCH; i++) begin
            if (mAck[i]) begin
                cl_tx_req[i] = 1'($urandom_range(0, 1));
                if (cl_tx_req[i]) cl_tx_data[i*PAYSZ +: PAYSZ] = PAYSZ'($urandom);
            end else if (!cl_tx_req[i] && $urandom_range(0, 3) == 0) begin
                cl_tx_req[i] = 1'b1;
                cl_tx_data[i*PAYSZ +: PAYSZ] = PAYSZ'($urandom);
            end
            cl_rx_ack[i] = ($urandom_range(0, 3) == 0);
        end
        link_dir = ($urandom_range(0, 3) != 0);
        if (mRd) link_dor = 1'b0;
        else if (!link_dor && $urandom_range(0, 2) == 0) begin
            link_dor  = 1'b1;
            link_dout = WORDSZ'($urandom);
        end
    endtask

    initial begin
        logic [PAYSZ-1:0] d [NCH];
        logic [PAYSZ-1:0] pay;
        int grants [$];
        int ackCount [NCH];
        int cnt;
        logic seen;

        modelReset();
        @(negedge clk);

        // Reset with every channel requesting: grants must come out ch0..ch3, one ack each.
        for (int i = 0; i < NCH; i++) begin
            d[i] = PAYSZ'(14'h1234 + i * 14'h0411);
            cl_tx_data[i*PAYSZ +: PAYSZ] = d[i];
            ackCount[i] = 0;
        end
        cl_tx_req = '1;
        link_dir  = 1'b1;
        repeat (2) applyStimulus();
        resetb = 1'b1;
        for (int n = 0; n < 20; n++) begin
            applyStimulus();
            if (n == 0) checkOutput("first_din", 64'(link_din), 64'({2'b00, d[0]}));
            if (link_wr) grants.push_back(int'(link_din[15:14]));
            for (int i = 0; i < NCH; i++) if (cl_tx_ack[i]) begin
                ackCount[i]++;
                cl_tx_req[i] = 1'b0;
            end
        end
        checkOutput("grant_cnt", 64'(grants.size()), 64'd4);
        for (int i = 0; i < grants.size() && i < NCH; i++) checkOutput("grant_order", 64'(grants[i]), 64'(i));
        for (int i = 0; i < NCH; i++) checkOutput("ack_pulses", 64'(ackCount[i]), 64'd1);

        // Only ch2 requesting while the link is busy.
        cl_tx_req = 4'b0100;
        link_dir  = 1'b0;
        cnt = 0;
        repeat (5) begin
            applyStimulus();
            cnt += int'(link_wr);
        end
        checkOutput("dir_block", 64'(cnt), 64'd0);
        link_dir = 1'b1;
        applyStimulus();
        checkOutput("dir_wr", 64'(link_wr), 64'd1);
        checkOutput("dir_id", 64'(link_din[15:14]), 64'd2);
        cl_tx_req = '0;
        repeat (4) applyStimulus();

        // Receive a word for ch2.
        link_dor  = 1'b1;
        link_dout = 16'h8ABC;
        applyStimulus();
        checkOutput("rx_v2", 64'(cl_rx_valid[2]), 64'd1);
        checkOutput("rx_d2", 64'(cl_rx_data[2*PAYSZ +: PAYSZ]), 64'h0ABC);
        checkOutput("rx_rd", 64'(link_rd), 64'd1);
        link_dor = 1'b0;
        applyStimulus();
        checkOutput("rx_rd_pulse", 64'(link_rd), 64'd0);
        applyStimulus();

        // Second ch2 word must stall until the client frees the register.
        link_dor  = 1'b1;
        link_dout = 16'h8123;
        cnt = 0;
        repeat (4) begin
            applyStimulus();
            cnt += int'(link_rd);
        end
        checkOutput("rx_stall", 64'(cnt), 64'd0);
        cl_rx_ack = 4'b0100;
        applyStimulus();
        cl_rx_ack = '0;
        seen = 1'b0;
        repeat (2) begin
            applyStimulus();
            if (link_rd) begin
                seen = 1'b1;
                link_dor = 1'b0;
            end
        end
        checkOutput("rx_unstall", 64'(seen), 64'd1);
        checkOutput("rx_d2b", 64'(cl_rx_data[2*PAYSZ +: PAYSZ]), 64'h0123);
        link_dor  = 1'b0;
        cl_rx_ack = 4'b0100;
        applyStimulus();
        cl_rx_ack = '0;
        repeat (3) applyStimulus();

        // Simultaneous TX grant and RX read.
        d[1] = PAYSZ'($urandom);
        pay  = PAYSZ'($urandom);
        cl_tx_data[1*PAYSZ +: PAYSZ] = d[1];
        cl_tx_req = 4'b0010;
        link_dir  = 1'b1;
        link_dor  = 1'b1;
        link_dout = {2'b01, pay};
        applyStimulus();
        checkOutput("sim_wr", 64'(link_wr), 64'd1);
        checkOutput("sim_rd", 64'(link_rd), 64'd1);
        checkOutput("sim_cs", 64'(link_cs), 64'd1);
        checkOutput("sim_din", 64'(link_din), 64'({2'b01, d[1]}));
        checkOutput("sim_rx", 64'(cl_rx_data[1*PAYSZ +: PAYSZ]), 64'(pay));
        cl_tx_req = '0;
        link_dor  = 1'b0;
        cl_rx_ack = 4'b0010;
        applyStimulus();
        cl_rx_ack = '0;
        repeat (4) applyStimulus();

        // Reset asserted while TX sits in T_WAIT and RX in R_HOLD.
        cl_tx_req = 4'b1000;
        applyStimulus();
        cl_tx_req = '0;
        link_dor  = 1'b1;
        link_dout = {2'b11, PAYSZ'($urandom)};
        applyStimulus();
        link_dor = 1'b0;
        link_dir = 1'b0;
        applyStimulus();
        resetb = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_valid", 64'(cl_rx_valid), 64'd0);
        checkOutput("rst_din", 64'(link_din), 64'd0);
        compareAll();
        @(negedge clk);
        applyStimulus();
        cl_tx_req = '1;
        link_dir  = 1'b1;
        resetb    = 1'b1;
        applyStimulus();
        checkOutput("post_rst_id", 64'(link_din[15:14]), 64'd0);
        checkOutput("post_rst_ack", 64'(cl_tx_ack), 64'b0001);

        // Randomized traffic with occasional mid-operation resets.
        for (int n = 0; n < 3000; n++) begin
            randomInputs();
            if (n % 700 == 350) begin
                resetb = 1'b0;
                #1;
                modelReset();
                compareAll();
                @(negedge clk);
                applyStimulus();
                resetb = 1'b1;
            end
            applyStimulus();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/osl_link_arb.md
# osl_link_arb

Channel arbiter and router for one `osl_rxtx` serial link. It shares the link's single host write/read port between `NCH` client channels. On transmit, it prefixes each payload with the source channel ID. On receive, it decodes the ID and steers the word into that channel's holding register. Backpressure applies on both sides. It sits between `osl_rxtx` (host side) and the client logic.

## Interface
Parameters:
- `WORDSZ`, 16: link word width; matches `osl_rxtx` `` `WORDSZ``.
- `CHIDSZ`, 2: channel ID width.
- `NCH`, 4: channel count; must equal `2**CHIDSZ`.
- `PAYSZ`, `WORDSZ-CHIDSZ`: client payload width (derived, not overridable).

Ports:
- `clk`  in  1  clock
- `resetb`  in  1  reset resetb, asynchronous, active-low; clock clk
- `cl_tx_req`  in  `NCH`  per-channel transmit request; held until ack
- `cl_tx_data`  in  `NCH*PAYSZ`  per-channel payload; channel i at `[i*PAYSZ +: PAYSZ]`
- `cl_tx_ack`  out  `NCH`  one-cycle pulse when the word is written to the link
- `cl_rx_valid`  out  `NCH`  holding register i is full
- `cl_rx_data`  out  `NCH*PAYSZ`  holding registers
- `cl_rx_ack`  in  `NCH`  client consumed the word; frees the register
- `link_cs`  out  1  to `osl_rxtx` `chip_sel`; equals `link_wr | link_rd`
- `link_wr`  out  1  to `host_wr`
- `link_din`  out  `WORDSZ`  to `host_din`; `{id, payload}`
- `link_dir`  in  1  from `host_dir`; 1 = link can accept a word
- `link_rd`  out  1  to `host_rd`
- `link_dout`  in  `WORDSZ`  from `host_dout`
- `link_dor`  in  1  from `host_dor`; 1 = received word available

## Operation
- **Reset values:** all outputs are 0, `rr_ptr` is 0, and both FSMs are in IDLE.
- **TX FSM** (T_IDLE, T_WRITE, T_HOLD, T_WAIT):
  - T_IDLE: if `link_dir` is 1 and any `cl_tx_req` is set, pick the winner `w`, register `link_din` as `{w[CHIDSZ-1:0], cl_tx_data[w]}`, and go to T_WRITE. Otherwise stay.
  - T_WRITE: `link_wr` and `cl_tx_ack[w]` are 1 for this cycle. Go to T_HOLD.
  - T_HOLD: one cycle that covers the `osl_rxtx` `host_dir` fall latency. Go to T_WAIT.
  - T_WAIT: stay until `link_dir` is 1, then go to T_IDLE.
- **Arbitration (default):** round-robin. Search from `rr_ptr` upward with modulo `NCH` wrap. On a grant, `rr_ptr` becomes `w+1` mod `NCH`.
- **RX FSM** (R_IDLE, R_READ, R_HOLD):
  - R_IDLE: if `link_dor` is 1, decode `c` from `link_dout[WORDSZ-1 -: CHIDSZ]`.
    - If `cl_rx_valid[c]` is 0: load `cl_rx_data[c]` with `link_dout[PAYSZ-1:0]`, set `cl_rx_valid[c]`, and go to R_READ.
    - If `cl_rx_valid[c]` is 1: stall in R_IDLE without reading. The link holds the word, and any remote sender is throttled by the link ack protocol.
  - R_READ: `link_rd` is 1 for one cycle. Go to R_HOLD.
  - R_HOLD: one cycle while `link_dor` falls. Go to R_IDLE.
- **Holding register:** `cl_rx_valid[i]` clears on `cl_rx_ack[i]`.
  - Load and ack cannot coincide on the same channel, because a load requires an empty register.
  - An ack while `cl_rx_valid[i]` is 0 is ignored.
  - A stalled word on channel c blocks every channel, because there is a single link FIFO of depth 1.
- **Independence:** the TX and RX FSMs run concurrently. `link_wr` and `link_rd` may both be high in one cycle, in which case `link_cs` is 1.
- **Mid-operation reset:** an async reset at any point returns everything to reset values. No pending ack or valid survives.

## Timing
- TX latency: `cl_tx_req` rises with T_IDLE and `link_dir` at 1 in cycle N. `link_wr` and `cl_tx_ack` are high in cycle N+1.
- TX throughput: at best one word per 3 + T_WAIT cycles. Link serialisation dominates.
- Clients must hold `cl_tx_data` stable until `cl_tx_ack`. It is sampled in the grant cycle. Dropping `cl_tx_req` before ack is legal only if the channel was not granted.
- RX latency: `link_dor` rises in cycle N with the target register empty. `cl_rx_valid` and `link_rd` are high in cycle N+1. The next word can be accepted no earlier than N+3.
- `link_dout` is sampled only in R_IDLE while `link_dor` is 1. `osl_rxtx` holds it stable in that window.

## Configuration
- `OSL_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, where the lowest index wins. `rr_ptr` is removed.
  - Undefined: round-robin as described in Operation.

## Test plan
- Reset with all requests high, then release → cycle 1 grants ch0, with `link_din` = `0x0000|data0` for `WORDSZ`=16. Then ch1, ch2, ch3 in order. Each `cl_tx_ack` is exactly one pulse.
- Only ch2 requesting with `link_dir`=0 → no `link_wr` until `link_dir` rises. `link_wr` follows one cycle later with `link_din`[15:14]=2.
- Word `0x8ABC` with `link_dor`=1 → `cl_rx_valid[2]`=1, `cl_rx_data[2]`=`0x0ABC`, and one `link_rd` pulse.
- Second word for ch2 before any ack → no `link_rd` while valid is 1. Pulse `cl_rx_ack[2]` → read completes within 2 cycles.
- Simultaneous TX grant and RX read → `link_wr`, `link_rd` and `link_cs` are all 1 in the same cycle, with correct data on both sides.
- Assert `resetb` while in T_WAIT and R_HOLD → all outputs are 0 on the next clock. After release, ch0 is granted first.
